// File: rtl/regfile_write_queue_pkg.sv
// Shared register-file definitions: widths, register count and the write request record.
package regfile_write_queue_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] sel;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Write-queue bus: request handshake, drain control, register file write port and hazard lookup.
interface regfile_write_queue_if #(
  parameter int DEPTH = 4
);
  import regfile_write_queue_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_sel;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              wr_ld;
  logic [ADDR_W-1:0] wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] lk_sel;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_sel, in_data, stall, lk_sel,
    input  in_ready, wr_ld, wr_sel, wr_data, lk_hit, lk_data, count
  );

  modport slave (
    input  in_valid, in_sel, in_data, stall, lk_sel,
    output in_ready, wr_ld, wr_sel, wr_data, lk_hit, lk_data, count
  );

endinterface

// File: rtl/regfile_wq_match.sv
// Youngest-match search over the queue entries, walking from head (oldest) towards tail.
module regfile_wq_match
  import regfile_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]             vld,
  input  logic [DEPTH-1:0][ADDR_W-1:0] sel,
  input  logic [DEPTH-1:0][DATA_W-1:0] data,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [ADDR_W-1:0]            lk_sel,
  output logic                         hit,
  output logic [DATA_W-1:0]            hit_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Later (younger) matches overwrite earlier ones, so the last match found wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (vld[idx] && (sel[idx] == lk_sel)) begin
        hit      = 1'b1;
        hit_data = data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write queue in front of the register file with a read-after-write lookup.
module regfile_write_queue
  import regfile_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  regfile_write_queue_if.slave bus
);
  localparam int               PTR_W = $clog2(DEPTH);
  localparam int               CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] q_sel;
  logic [DEPTH-1:0][DATA_W-1:0] q_data;
  logic [DEPTH-1:0]             q_vld;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [CNT_W-1:0]             cnt;
  logic                         push;
  logic                         pop;
  wr_req_t                      in_req;
  wr_req_t                      out_q;
  logic                         out_ld;
  logic                         q_hit;
  logic [DATA_W-1:0]            q_hit_data;
  logic                         out_hit;

  // Ready depends only on the registered count, so a full queue refuses even while draining.
  assign in_req = '{sel: bus.in_sel, data: bus.in_data};
  assign push   = bus.in_valid && (cnt != FULL);
  assign pop    = (cnt != '0) && !bus.stall;

  // Entry payload storage; contents are qualified by q_vld so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_sel[tail]  <= in_req.sel;
      q_data[tail] <= in_req.data;
    end
  end

  // Pointers, valid bits and occupancy; pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      q_vld <= '0;
    end else begin
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (push) begin
        q_vld[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Output stage: one-cycle load strobe per pop; select and data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ld <= 1'b0;
      out_q  <= '0;
    end else begin
      out_ld <= pop;
      if (pop) begin
        out_q <= '{sel: q_sel[head], data: q_data[head]};
      end
    end
  end

  regfile_wq_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .vld      (q_vld),
    .sel      (q_sel),
    .data     (q_data),
    .head     (head),
    .lk_sel   (bus.lk_sel),
    .hit      (q_hit),
    .hit_data (q_hit_data)
  );

  // The output stage is the oldest candidate, so any queue match takes priority over it.
  always_comb begin
    out_hit     = out_ld && (out_q.sel == bus.lk_sel);
    bus.lk_hit  = q_hit || out_hit;
    bus.lk_data = '0;
    if (q_hit) begin
      bus.lk_data = q_hit_data;
    end else if (out_hit) begin
      bus.lk_data = out_q.data;
    end
  end

  assign bus.in_ready = (cnt != FULL);
  assign bus.count    = cnt;
  assign bus.wr_ld    = out_ld;
  assign bus.wr_sel   = out_q.sel;
  assign bus.wr_data  = out_q.data;

endmodule
